coherence_bus_ctrl: RTL and testbench

Snooping coherence and memory controller for the dual-core system. It sits directly downstream of both cores' dcaches and icaches, and arbitrates their miss, writeback and upgrade requests onto the single RAM port. It drives the snoop interface (ccwait/ccinv/ccsnoopaddr) into the peer dcache and services cache-to-cache transfers for a two-word-block MSI protocol.

---
 rtl/coherence_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Snooping MSI coherence and memory controller for two cores sharing one RAM port.
// Arbitrates icache/dcache traffic, drives the peer snoop interface and forwards dirty blocks.
module coherence_bus_ctrl #(
    parameter int unsigned CPUS = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0][31:0]    iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0][31:0]    iload,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0][31:0]    daddr,
    input  logic [CPUS-1:0][31:0]    dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS-1:0][31:0]    dload,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS-1:0][31:0]    ccsnoopaddr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [31:0]              ramaddr,
    output logic [31:0]              ramstore,
    input  logic [31:0]              ramload,
    input  logic [1:0]               ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE, IFETCH, WB0, WB1, SNOOP, FWD0, FWD1, MEM0, MEM1, INV
    } state_t;

    state_t                  state, state_n;
    logic                    req, req_n;
    logic                    last, last_n;
    logic                    inv_q, inv_n;
    logic [CPUS-1:0][31:0]   snoop_q, snoop_n;
    logic                    snp;
    logic                    access;
    logic [CPUS-1:0]         wb_req;

    assign snp    = ~req;
    assign access = (ramstate == RAM_ACCESS);
    assign wb_req = dWEN & ~cctrans;

    // Two-way round robin: on a tie the core that was not served last wins.
    function automatic logic pick(input logic [1:0] v, input logic lst);
        if (v == 2'b11) return ~lst;
        return v[1];
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            req     <= 1'b0;
            last    <= 1'b1;
            inv_q   <= 1'b0;
            snoop_q <= '0;
        end else begin
            state   <= state_n;
            req     <= req_n;
            last    <= last_n;
            inv_q   <= inv_n;
            snoop_q <= snoop_n;
        end
    end

    // Arbitration and transaction sequencing; ERROR on the RAM side simply never advances.
    always_comb begin
        state_n = state;
        req_n   = req;
        last_n  = last;
        inv_n   = inv_q;
        snoop_n = snoop_q;
        case (state)
            IDLE: begin
                if (|wb_req) begin
                    state_n = WB0;
                    req_n   = pick(wb_req, last);
                end else if (|cctrans) begin
                    state_n          = SNOOP;
                    req_n            = pick(cctrans, last);
                    inv_n            = ccwrite[req_n];
                    snoop_n[~req_n]  = daddr[req_n];
                end else if (|iREN) begin
                    state_n = IFETCH;
                    req_n   = pick(iREN, last);
                end
            end
            IFETCH: if (access) begin state_n = IDLE; last_n = ~last; end
            WB0:    if (access) state_n = WB1;
            WB1:    if (access) begin state_n = IDLE; last_n = ~last; end
            SNOOP: begin
                if (ccwrite[snp])    state_n = FWD0;
                else if (dREN[req])  state_n = MEM0;
                else                 state_n = INV;
            end
            FWD0:   if (access) state_n = FWD1;
            FWD1:   if (access) begin state_n = IDLE; last_n = ~last; end
            MEM0:   if (access) state_n = MEM1;
            MEM1:   if (access) begin state_n = IDLE; last_n = ~last; end
            INV:    begin state_n = IDLE; last_n = ~last; end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs decoded from the current state and the granted core.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = snoop_q;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[req];
                iload[req] = ramload;
                iwait[req] = ~access;
            end
            WB0, WB1: begin
                ramWEN     = 1'b1;
                ramaddr    = {daddr[req][31:3], (state == WB1), daddr[req][1:0]};
                ramstore   = dstore[req];
                dwait[req] = ~access;
            end
            SNOOP: begin
                ccwait[snp] = 1'b1;
                ccinv[snp]  = inv_q;
            end
            FWD0, FWD1: begin
                ccwait[snp] = 1'b1;
                ccinv[snp]  = inv_q;
                ramWEN      = 1'b1;
                ramaddr     = daddr[snp];
                ramstore    = dstore[snp];
                dload[req]  = dstore[snp];
                dwait[req]  = ~access;
                dwait[snp]  = ~access;
            end
            MEM0, MEM1: begin
                ccwait[snp] = 1'b1;
                ccinv[snp]  = inv_q;
                ramREN      = 1'b1;
                ramaddr     = daddr[req];
                dload[req]  = ramload;
                dwait[req]  = ~access;
            end
            INV: begin
                ccwait[snp] = 1'b1;
                ccinv[snp]  = inv_q;
                dwait[req]  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed vector bench for coherence_bus_ctrl: per-cycle input/expected-output records
// plus a hand sequence for asynchronous reset in the middle of a stalled forward.
module tb_coherence_bus_ctrl;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [1:0]        iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
    logic [1:0][31:0]  iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic [1:0]        ramstate, stall;

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    always #5 CLK = ~CLK;

    // RAM model: single-cycle ACCESS unless a stall code is forced.
    assign ramstate = (stall != 2'd0) ? stall : ((ramREN || ramWEN) ? 2'd2 : 2'd0);
    assign ramload  = (ramaddr == 32'h40) ? 32'hDEAD_BEEF : ~ramaddr;

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  iren, dren, dwen, cct, ccw, stall;
        logic [31:0] a0, a1, st1;
        logic [1:0]  iw, dw, cw, ci;
        logic        rr, rw;
        logic [31:0] raddr, rstore, il0, il1, dl0, dl1, sa0, sa1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t vec(
        input logic rst, input logic [1:0] iren, dren, dwen, cct, ccw, stl,
        input logic [31:0] a0, a1, st1,
        input logic [1:0] iw, dw, cw, ci, input logic rr, rw,
        input logic [31:0] raddr, rstore, il0, il1, dl0, dl1, sa0, sa1);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen; v.cct = cct; v.ccw = ccw;
        v.stall = stl; v.a0 = a0; v.a1 = a1; v.st1 = st1;
        v.iw = iw; v.dw = dw; v.cw = cw; v.ci = ci; v.rr = rr; v.rw = rw;
        v.raddr = raddr; v.rstore = rstore; v.il0 = il0; v.il1 = il1;
        v.dl0 = dl0; v.dl1 = dl1; v.sa0 = sa0; v.sa1 = sa1;
        return v;
    endfunction

    // Cycle spent in IDLE: every output at its quiescent value.
    function automatic vec_t idle(
        input logic rst, input logic [1:0] iren, dren, dwen, cct, ccw, stl,
        input logic [31:0] a0, a1, st1, sa0, sa1);
        return vec(rst, iren, dren, dwen, cct, ccw, stl, a0, a1, st1,
                   2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, sa0, sa1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %h, expected %h", nm, cur, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        if (v.rst) begin
            nRST = 1'b0;
            #1;
            nRST = 1'b1;
        end
        iREN = v.iren; dREN = v.dren; dWEN = v.dwen; cctrans = v.cct; ccwrite = v.ccw;
        stall = v.stall;
        iaddr[0] = v.a0; iaddr[1] = v.a1; daddr[0] = v.a0; daddr[1] = v.a1;
        dstore[0] = 32'h0; dstore[1] = v.st1;
        #1;
        chk("iwait",    32'(iwait),    32'(v.iw));
        chk("dwait",    32'(dwait),    32'(v.dw));
        chk("ccwait",   32'(ccwait),   32'(v.cw));
        chk("ccinv",    32'(ccinv),    32'(v.ci));
        chk("ramREN",   32'(ramREN),   32'(v.rr));
        chk("ramWEN",   32'(ramWEN),   32'(v.rw));
        chk("ramaddr",  ramaddr,  v.raddr);
        chk("ramstore", ramstore, v.rstore);
        chk("iload0",   iload[0], v.il0);
        chk("iload1",   iload[1], v.il1);
        chk("dload0",   dload[0], v.dl0);
        chk("dload1",   dload[1], v.dl1);
        chk("snoop0",   ccsnoopaddr[0], v.sa0);
        chk("snoop1",   ccsnoopaddr[1], v.sa1);
        cur++;
    endtask

    initial begin
        nRST = 1'b0; stall = 2'd0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0;

        // Reset then icache fetch of 0x40
        tbl.push_back(idle(1, 2'b01, 0, 0, 0, 0, 0, 'h40, 0, 0, 0, 0));
        tbl.push_back(vec (0, 2'b01, 0, 0, 0, 0, 0, 'h40, 0, 0, 2'b10, 2'b11, 0, 0, 1, 0, 'h40, 0, 'hDEADBEEF, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 'h40, 0, 0, 0, 0));
        // Read miss by core1, clean peer, one ERROR stall in MEM0
        tbl.push_back(idle(1, 0, 2'b10, 0, 2'b10, 0, 0, 0, 'h100, 0, 0, 0));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 0, 0, 'h100, 0, 2'b11, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h100, 0));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 3, 0, 'h100, 0, 2'b11, 2'b11, 2'b01, 0, 1, 0, 'h100, 0, 0, 0, 0, 'hFFFFFEFF, 'h100, 0));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 0, 0, 'h100, 0, 2'b11, 2'b01, 2'b01, 0, 1, 0, 'h100, 0, 0, 0, 0, 'hFFFFFEFF, 'h100, 0));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 0, 0, 'h104, 0, 2'b11, 2'b01, 2'b01, 0, 1, 0, 'h104, 0, 0, 0, 0, 'hFFFFFEFB, 'h100, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 'h104, 0, 'h100, 0));
        // BusRdX by core0, dirty core1 forwards 0x11/0x22; core0 drops its request during FWD1
        tbl.push_back(idle(1, 0, 2'b01, 0, 2'b01, 2'b11, 0, 'h200, 'h200, 'h11, 0, 0));
        tbl.push_back(vec (0, 0, 2'b01, 0, 2'b01, 2'b11, 0, 'h200, 'h200, 'h11, 2'b11, 2'b11, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h200));
        tbl.push_back(vec (0, 0, 2'b01, 2'b10, 2'b01, 2'b11, 0, 'h200, 'h200, 'h11, 2'b11, 2'b00, 2'b10, 2'b10, 0, 1, 'h200, 'h11, 0, 0, 'h11, 0, 0, 'h200));
        tbl.push_back(vec (0, 0, 0, 2'b10, 0, 2'b10, 0, 'h204, 'h204, 'h22, 2'b11, 2'b00, 2'b10, 2'b10, 0, 1, 'h204, 'h22, 0, 0, 'h22, 0, 0, 'h200));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h200));
        // Upgrade by core1: SNOOP then INV, no RAM traffic
        tbl.push_back(idle(1, 0, 0, 0, 2'b10, 2'b10, 0, 0, 'h300, 0, 0, 0));
        tbl.push_back(vec (0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 'h300, 0, 2'b11, 2'b11, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 'h300, 0));
        tbl.push_back(vec (0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 'h300, 0, 2'b11, 2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 'h300, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 'h300, 0, 'h300, 0));
        // Both cores miss together: core0 first, then core1
        tbl.push_back(idle(1, 0, 2'b11, 0, 2'b11, 0, 0, 'h400, 'h500, 0, 0, 0));
        tbl.push_back(vec (0, 0, 2'b11, 0, 2'b11, 0, 0, 'h400, 'h500, 0, 2'b11, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h400));
        tbl.push_back(vec (0, 0, 2'b11, 0, 2'b11, 0, 0, 'h400, 'h500, 0, 2'b11, 2'b10, 2'b10, 0, 1, 0, 'h400, 0, 0, 0, 'hFFFFFBFF, 0, 0, 'h400));
        tbl.push_back(vec (0, 0, 2'b11, 0, 2'b11, 0, 0, 'h404, 'h500, 0, 2'b11, 2'b10, 2'b10, 0, 1, 0, 'h404, 0, 0, 0, 'hFFFFFBFB, 0, 0, 'h400));
        tbl.push_back(idle(0, 0, 2'b10, 0, 2'b10, 0, 0, 'h404, 'h500, 0, 0, 'h400));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 0, 'h404, 'h500, 0, 2'b11, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h500, 'h400));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 0, 'h404, 'h500, 0, 2'b11, 2'b01, 2'b01, 0, 1, 0, 'h500, 0, 0, 0, 0, 'hFFFFFAFF, 'h500, 'h400));
        tbl.push_back(vec (0, 0, 2'b10, 0, 2'b10, 0, 0, 'h404, 'h504, 0, 2'b11, 2'b01, 2'b01, 0, 1, 0, 'h504, 0, 0, 0, 0, 'hFFFFFAFB, 'h500, 'h400));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 'h404, 'h504, 0, 'h500, 'h400));
        // Eviction by core1 beats core0 ifetch; one BUSY cycle in WB0
        tbl.push_back(idle(1, 2'b01, 0, 2'b10, 0, 0, 0, 'h40, 'h608, 'hAA, 0, 0));
        tbl.push_back(vec (0, 2'b01, 0, 2'b10, 0, 0, 1, 'h40, 'h608, 'hAA, 2'b11, 2'b11, 0, 0, 0, 1, 'h608, 'hAA, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vec (0, 2'b01, 0, 2'b10, 0, 0, 0, 'h40, 'h608, 'hAA, 2'b11, 2'b01, 0, 0, 0, 1, 'h608, 'hAA, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vec (0, 2'b01, 0, 2'b10, 0, 0, 0, 'h40, 'h608, 'hBB, 2'b11, 2'b01, 0, 0, 0, 1, 'h60C, 'hBB, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 2'b01, 0, 0, 0, 0, 0, 'h40, 'h608, 0, 0, 0));
        tbl.push_back(vec (0, 2'b01, 0, 0, 0, 0, 0, 'h40, 'h608, 0, 2'b10, 2'b11, 0, 0, 1, 0, 'h40, 0, 'hDEADBEEF, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 'h40, 'h608, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Async reset while FWD1 is stalled on a BUSY RAM
        apply(idle(1, 0, 2'b01, 0, 2'b01, 2'b11, 0, 'h200, 'h200, 'h11, 0, 0));
        apply(vec (0, 0, 2'b01, 0, 2'b01, 2'b11, 0, 'h200, 'h200, 'h11, 2'b11, 2'b11, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h200));
        apply(vec (0, 0, 2'b01, 2'b10, 2'b01, 2'b11, 0, 'h200, 'h200, 'h11, 2'b11, 2'b00, 2'b10, 2'b10, 0, 1, 'h200, 'h11, 0, 0, 'h11, 0, 0, 'h200));
        apply(vec (0, 0, 2'b01, 2'b10, 2'b01, 2'b11, 1, 'h204, 'h204, 'h22, 2'b11, 2'b11, 2'b10, 2'b10, 0, 1, 'h204, 'h22, 0, 0, 'h22, 0, 0, 'h200));
        #1 nRST = 1'b0;
        #1;
        chk("rst_iwait",    32'(iwait),   32'h3);
        chk("rst_dwait",    32'(dwait),   32'h3);
        chk("rst_ccwait",   32'(ccwait),  32'h0);
        chk("rst_ccinv",    32'(ccinv),   32'h0);
        chk("rst_ramWEN",   32'(ramWEN),  32'h0);
        chk("rst_ramaddr",  ramaddr,      32'h0);
        chk("rst_ramstore", ramstore,     32'h0);
        chk("rst_dload0",   dload[0],     32'h0);
        chk("rst_snoop1",   ccsnoopaddr[1], 32'h0);
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; stall = 2'd0;
        nRST = 1'b1;
        apply(idle(0, 2'b10, 0, 0, 0, 0, 0, 0, 'h80, 0, 0, 0));
        apply(vec (0, 2'b10, 0, 0, 0, 0, 0, 0, 'h80, 0, 2'b01, 2'b11, 0, 0, 1, 0, 'h80, 0, 0, 'hFFFFFF7F, 0, 0, 0, 0));
        apply(idle(0, 0, 0, 0, 0, 0, 0, 0, 'h80, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
